// File: rtl/expr_pkg.sv
// Shared constants and state encoding for the arithmetic-expression protocol.
// Used by the emitter and by the expression checker on the receiving side.
package expr_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    OP    = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] op_char(input logic op);
    return (op == OP_MUL) ? CH_STAR : CH_PLUS;
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CH_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/expr_term_sel.sv
// Selects the current operand/operator from the latched vectors and encodes it
// as the ASCII character to present on the stream.
module expr_term_sel
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = 8,
  parameter int CNT_W     = 4
) (
  input  logic [4*MAX_TERMS-1:0] digits_q,
  input  logic [MAX_TERMS-2:0]   ops_q,
  input  logic [CNT_W-1:0]       idx,
  input  logic                   is_op,
  output logic [7:0]             code
);

  logic [3:0] dsel;
  logic       osel;

  // Index-driven mux over the latched terms and operators
  always_comb begin
    dsel = 4'h0;
    osel = OP_ADD;
    for (int i = 0; i < MAX_TERMS; i++) begin
      dsel = (idx == CNT_W'(i)) ? digits_q[4*i +: 4] : dsel;
    end
    for (int i = 0; i < MAX_TERMS - 1; i++) begin
      osel = (idx == CNT_W'(i)) ? ops_q[i] : osel;
    end
    code = is_op ? op_char(osel) : digit_char(dsel);
  end

endmodule

// File: rtl/expr_emit.sv
// Expression transmitter: latches a request and streams "digit (op digit)*"
// one ASCII character per valid/ready handshake.
module expr_emit
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = 8,
  parameter int CNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       term_cnt,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic [7:0]             ch,
  output logic                   ch_valid,
  input  logic                   ch_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t                 state;
  state_t                 state_nx;
  logic [CNT_W-1:0]       idx;
  logic [CNT_W-1:0]       n_q;
  logic [4*MAX_TERMS-1:0] digits_q;
  logic [MAX_TERMS-2:0]   ops_q;
  logic                   err_q;
  logic                   req_ok;
  logic                   load;
  logic [7:0]             code;

  // Request validity: count in range and every used term is a BCD digit
  always_comb begin
    req_ok = (term_cnt != {CNT_W{1'b0}}) && (term_cnt <= CNT_W'(MAX_TERMS));
    for (int i = 0; i < MAX_TERMS; i++) begin
      if ((CNT_W'(i) < term_cnt) && (digits[4*i +: 4] > 4'd9)) begin
        req_ok = 1'b0;
      end else begin
        req_ok = req_ok;
      end
    end
  end

  assign load = (state == IDLE) && start && req_ok;

  // Next-state logic; outputs are decoded from the registered state only
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = load ? DIGIT : IDLE;
      DIGIT: begin
        if (ch_ready) begin
          state_nx = (idx == n_q - CNT_W'(1)) ? DONE : OP;
        end else begin
          state_nx = DIGIT;
        end
      end
      OP:      state_nx = ch_ready ? DIGIT : OP;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, index, request latches and the error pulse
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      idx      <= {CNT_W{1'b0}};
      n_q      <= {CNT_W{1'b0}};
      digits_q <= {(4*MAX_TERMS){1'b0}};
      ops_q    <= {(MAX_TERMS-1){1'b0}};
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= (state == IDLE) && start && !req_ok;
      if (load) begin
        n_q      <= term_cnt;
        digits_q <= digits;
        ops_q    <= ops;
        idx      <= {CNT_W{1'b0}};
      end else if ((state == OP) && ch_ready) begin
        idx <= idx + CNT_W'(1);
      end else begin
        idx <= idx;
      end
    end
  end

  expr_term_sel #(
    .MAX_TERMS(MAX_TERMS),
    .CNT_W    (CNT_W)
  ) u_sel (
    .digits_q(digits_q),
    .ops_q   (ops_q),
    .idx     (idx),
    .is_op   (state == OP),
    .code    (code)
  );

  assign ch_valid = (state == DIGIT) || (state == OP);
  assign busy     = ch_valid;
  assign done     = (state == DONE);
  assign err      = err_q;
  assign ch       = ch_valid ? code : 8'h00;

endmodule

// File: tb/tb_expr_emit.sv
// Randomized bench for expr_emit: a queue-based model of the expected character
// stream is checked against the DUT every cycle, plus directed literal scenarios.
module tb_expr_emit;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  term_cnt = 4'd0;
  logic [31:0] digits = 32'h0;
  logic [6:0]  ops = 7'h0;
  logic [7:0]  ch;
  logic        ch_valid;
  logic        ch_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  // model: characters still to be sent, plus pending one-cycle pulses
  logic [7:0] pend[$];
  logic [7:0] log_q[$];
  bit         done_due = 1'b0;
  bit         err_due = 1'b0;
  int         step_no = 0;
  int         done_at = -1;
  int         busy_cnt = 0;
  int         err_cnt = 0;
  int         done_cnt = 0;

  expr_emit #(.MAX_TERMS(8), .CNT_W(4)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .term_cnt(term_cnt),
    .digits(digits), .ops(ops), .ch(ch), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (step %0d)", nm, act, exp, step_no);
    end
  endtask

  function automatic bit req_valid(input logic [3:0] n, input logic [31:0] dg);
    logic [31:0] d;
    if (n == 4'd0 || n > 4'd8) return 1'b0;
    d = dg;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n) && d[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One cycle: compare at negedge, drive inputs, advance the model past the next edge
  task automatic step(input bit rdy, input bit st, input logic [3:0] n,
                      input logic [31:0] dg, input logic [6:0] op);
    bit done_n;
    bit err_n;
    logic [7:0] exp_ch;
    @(negedge clk);
    exp_ch = (pend.size() > 0) ? pend[0] : 8'h00;
    chk("ch", {24'h0, ch}, {24'h0, exp_ch});
    chk("ch_valid", {31'h0, ch_valid}, {31'h0, pend.size() > 0});
    chk("busy", {31'h0, busy}, {31'h0, pend.size() > 0});
    chk("done", {31'h0, done}, {31'h0, done_due});
    chk("err", {31'h0, err}, {31'h0, err_due});
    if (busy) busy_cnt++;
    if (err) err_cnt++;
    if (done) begin
      done_cnt++;
      done_at = step_no;
    end
    ch_ready = rdy;
    start    = st;
    term_cnt = n;
    digits   = dg;
    ops      = op;
    done_n = 1'b0;
    err_n  = 1'b0;
    if (pend.size() > 0) begin
      if (rdy) begin
        log_q.push_back(pend.pop_front());
        if (pend.size() == 0) done_n = 1'b1;
      end
    end else if (!done_due && st) begin
      if (req_valid(n, dg)) begin
        for (int i = 0; i < int'(n); i++) begin
          pend.push_back(8'h30 + {4'h0, dg[4*i +: 4]});
          if (i < int'(n) - 1) pend.push_back(op[i] ? 8'h2A : 8'h2B);
        end
      end else begin
        err_n = 1'b1;
      end
    end
    done_due = done_n;
    err_due  = err_n;
    step_no++;
  endtask

  task automatic clear_stats();
    log_q.delete();
    step_no  = 0;
    done_at  = -1;
    busy_cnt = 0;
    err_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 4'd0, 32'h0, 7'h0);
  endtask

  logic [7:0] seq1 [5];

  initial begin
    seq1[0] = 8'h35; seq1[1] = 8'h2B; seq1[2] = 8'h32; seq1[3] = 8'h2A; seq1[4] = 8'h37;

    #12;
    chk("rst_ch", {24'h0, ch}, 32'h0);
    chk("rst_valid", {31'h0, ch_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    clr_n = 1'b1;

    // n=3, 5+2*7, ready held high
    clear_stats();
    step(1'b1, 1'b1, 4'd3, 32'h0000_0725, 7'b0000010);
    idle(8);
    chk("s1_len", log_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) chk("s1_char", {24'h0, log_q[i]}, {24'h0, seq1[i]});
    chk("s1_busy", busy_cnt, 32'd5);
    chk("s1_done_at", done_at, 32'd6);
    chk("s1_done_cnt", done_cnt, 32'd1);

    // n=1, single digit 9
    clear_stats();
    step(1'b1, 1'b1, 4'd1, 32'hFFFF_FFF9, 7'h7F);
    idle(4);
    chk("s2_len", log_q.size(), 32'd1);
    chk("s2_char", {24'h0, log_q[0]}, 32'h39);
    chk("s2_done_at", done_at, 32'd2);

    // same as first, stalled 3 cycles in OP, inputs scrambled after load
    clear_stats();
    step(1'b1, 1'b1, 4'd3, 32'h0000_0725, 7'b0000010);
    step(1'b1, 1'b0, 4'd8, 32'h1111_1111, 7'h7F);
    step(1'b0, 1'b1, 4'd8, 32'h1111_1111, 7'h7F);
    step(1'b0, 1'b1, 4'd2, 32'h2222_2222, 7'h00);
    step(1'b0, 1'b0, 4'd2, 32'h2222_2222, 7'h00);
    idle(8);
    chk("s3_len", log_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) chk("s3_char", {24'h0, log_q[i]}, {24'h0, seq1[i]});
    chk("s3_busy", busy_cnt, 32'd8);
    chk("s3_done_at", done_at, 32'd9);

    // rejected requests: n=0, then n=2 with a non-BCD second term
    clear_stats();
    step(1'b1, 1'b1, 4'd0, 32'h0, 7'h0);
    step(1'b1, 1'b0, 4'd0, 32'h0, 7'h0);
    step(1'b1, 1'b1, 4'd2, 32'h0000_00A3, 7'h0);
    idle(3);
    chk("s4_err_cnt", err_cnt, 32'd2);
    chk("s4_busy", busy_cnt, 32'd0);
    chk("s4_done_cnt", done_cnt, 32'd0);

    // abort after two accepted characters
    clear_stats();
    step(1'b1, 1'b1, 4'd4, 32'h0000_1234, 7'b0000101);
    step(1'b1, 1'b0, 4'd0, 32'h0, 7'h0);
    step(1'b1, 1'b0, 4'd0, 32'h0, 7'h0);
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk("abort_valid", {31'h0, ch_valid}, 32'h0);
    chk("abort_ch", {24'h0, ch}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    pend.delete();
    done_due = 1'b0;
    err_due  = 1'b0;
    #2;
    clr_n = 1'b1;
    idle(4);
    chk("abort_len", log_q.size(), 32'd2);
    chk("abort_done_cnt", done_cnt, 32'd0);

    // randomized traffic, inputs keep changing while busy
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] dg;
      dg = 32'h0;
      for (int i = 0; i < 8; i++) begin
        dg[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           4'($urandom_range(0, 9)), dg, 7'($urandom));
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/expr_emit.md
# expr_emit

Character-stream transmitter for the FSM lab's arithmetic-expression protocol. It takes a loaded set of single-digit operands and operators and emits them one ASCII character per accepted handshake, in the form `digit (op digit)*` with op ∈ {'+','*'}. Its output is always a well-formed expression for the expression-checker FSM, so the two form a loopback pair in the lab testbench.

## Interface
Parameters:
- MAX_TERMS, 8, maximum operand count per expression (1..15)
- CNT_W, 4, width of the term count and index; MAX_TERMS ≤ 2^CNT_W−1

Ports:
- clk  in  1  clock, rising edge
- clr_n  in  1  reset, asynchronous and active-low
- start  in  1  load request; sampled only in IDLE
- term_cnt  in  CNT_W  operand count n
- digits  in  4·MAX_TERMS  BCD operands; term i at bits [4i+3:4i]
- ops  in  MAX_TERMS−1  bit i is the operator between term i and term i+1: 0 = '+', 1 = '*'
- ch  out  8  ASCII character
- ch_valid  out  1  ch is valid
- ch_ready  in  1  sink accepts ch this cycle
- busy  out  1  high while an expression is being emitted (DIGIT/OP)
- done  out  1  one-cycle pulse after the final character is accepted
- err  out  1  one-cycle pulse when a start is rejected

## Operation
- States: IDLE, DIGIT, OP, DONE. Registered state, index idx (CNT_W), latched copies of n, digits and ops.
- IDLE with start=1:
  - Invalid request: n=0, n>MAX_TERMS, or any digit in terms 0..n−1 is greater than 9. Assert err next cycle, stay in IDLE, emit nothing.
  - Valid request: latch inputs, set idx=0, go to DIGIT.
- DIGIT: ch = 8'h30 + digit[idx], ch_valid=1. On handshake (ch_valid & ch_ready):
  - idx == n−1: go to DONE.
  - otherwise: go to OP.
- OP: ch = ops[idx] ? 8'h2A : 8'h2B, ch_valid=1. On handshake, idx ← idx+1 and go to DIGIT.
- DONE: ch_valid=0, done=1 for exactly one cycle, then go to IDLE.
- Total characters per expression: 2n−1. Digits beyond term n−1 and ops beyond bit n−2 are ignored, including when checking validity.
- start outside IDLE is ignored. Input changes after the load have no effect; the latched copies are used.
- ch=0 whenever ch_valid=0.

## Timing
- Reset values: state=IDLE, idx=0, ch=8'h00, ch_valid=0, busy=0, done=0, err=0.
- Reset is asynchronous. Asserting clr_n mid-expression aborts immediately; no further characters and no done.
- Latency from start:
  - Start sampled at edge t: ch_valid=1 from t+1 with the first digit.
  - With ch_ready held high, one character per cycle and done in cycle t+2n.
- Handshake rules:
  - Transfer occurs on a rising edge with ch_valid & ch_ready.
  - While ch_valid=1 and ch_ready=0, ch and ch_valid are held stable.
  - ch_valid never depends combinationally on ch_ready.
- err and done are never asserted together. Back-to-back use: a start in the cycle after DONE (state is IDLE) is accepted.
- idx never exceeds n−1; there is no wrap-around.

## Structure
- Shared package expr_pkg:
  - ASCII constants CH_ZERO=8'h30, CH_PLUS=8'h2B, CH_STAR=8'h2A.
  - Operator encoding (OP_ADD=0, OP_MUL=1).
  - State enum {IDLE, DIGIT, OP, DONE}.
  - Used by both this block and the checker.
- One sub-module, expr_term_sel: combinational select of digit[idx] and ops[idx] from the latched vectors, plus the ASCII encode. The FSM, index and latches stay in expr_emit.

## Test plan
- n=3, terms {5,2,7}, ops=2'b10, ch_ready=1 → ch 0x35, 0x2B, 0x32, 0x2A, 0x37 on five consecutive cycles; done in the 6th; busy high for exactly 5 cycles.
- n=1, term0=9 → a single 0x39, then done; no operator is emitted.
- Same request as the first scenario, with ch_ready low for 3 cycles while in OP → ch stays 0x2B with ch_valid=1 for all 3 cycles; sequence otherwise unchanged.
- n=0, then n=2 with term1=4'hA → err pulses for one cycle each time; ch_valid stays 0; state stays IDLE.
- start pulsed mid-expression → ignored. clr_n pulled low after 2 accepted characters → ch_valid=0 and ch=0 immediately; no done.
- Loopback into the checker (clr released, n=4) → checker output high after each accepted digit, and high after the final character.
